wbm_ctrl_master: RTL

Wishbone classic-cycle initiator that drives the accelerator's control slave from a simple command/response port. It turns one 64-bit command into one or two 32-bit bus beats on the accelerator address map, covering the mode/debug registers, query-patch memory, leaf memory, best array and node memory. It sits on the host/test side of the slave port and is used for loading queries and leaves and for reading results back.

---
 rtl/wbm_ctrl_pkg.sv | 34 +++
 rtl/wbm_ctrl_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wbm_ctrl_pkg.sv
// Shared address map, region and FSM encodings for the accelerator control-slave initiator.
// The slave model and benches import the same constants.
package wbm_ctrl_pkg;

    localparam logic [31:0] WBS_MODE_ADDR  = 32'h3000_0000;
    localparam logic [31:0] WBS_DEBUG_ADDR = 32'h3000_0001;
    localparam logic [31:0] WBS_QUERY_ADDR = 32'h3100_0000;
    localparam logic [31:0] WBS_LEAF_ADDR  = 32'h3200_0000;
    localparam logic [31:0] WBS_BEST_ADDR  = 32'h3300_0000;
    localparam logic [31:0] WBS_NODE_ADDR  = 32'h3400_0000;
    localparam logic [31:0] WBS_ADDR_MASK  = 32'hF000_0000;

    localparam int QUERY_W = 55;

    typedef enum logic [2:0] {
        REGION_REG   = 3'd0,
        REGION_QUERY = 3'd1,
        REGION_LEAF  = 3'd2,
        REGION_BEST  = 3'd3,
        REGION_NODE  = 3'd4
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic is_two_beat(input logic [2:0] region);
        return (region == REGION_QUERY) || (region == REGION_LEAF) || (region == REGION_BEST);
    endfunction

endpackage

// File: rtl/wbm_ctrl_master.sv
// Wishbone classic initiator: one 64-bit command becomes one or two 32-bit beats
// on the accelerator control map, with a per-beat ack timeout.
module wbm_ctrl_master
    import wbm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 11,
    parameter int PATCH_SIZE     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [2:0]  cmd_region,
    input  logic [15:0] cmd_index,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int              QW       = DATA_WIDTH * PATCH_SIZE;
    localparam logic [63:0]     QMASK    = (QW >= 64) ? '1 : ((64'd1 << QW) - 64'd1);
    localparam logic [31:0]     QHI_MASK = QMASK[63:32];
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Address of the lower (or only) beat; the upper beat is always this plus one.
    function automatic logic [31:0] beat_addr(input logic [2:0] region, input logic [15:0] index);
        case (region_e'(region))
            REGION_REG:   return WBS_MODE_ADDR  + {16'd0, index};
            REGION_QUERY: return WBS_QUERY_ADDR + {15'd0, index, 1'b0};
            REGION_LEAF:  return WBS_LEAF_ADDR  + {15'd0, index, 1'b0};
            REGION_BEST:  return WBS_BEST_ADDR  + {15'd0, index, 1'b0};
            REGION_NODE:  return WBS_NODE_ADDR  + {16'd0, index};
            default:      return 32'd0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              two_q, two_d;
    logic              half_q, half_d;
    logic              query_q, query_d;
    logic [31:0]       hi_q, hi_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              rvld_q, rvld_d;
    logic              rerr_q, rerr_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            two_q   <= 1'b0;
            half_q  <= 1'b0;
            query_q <= 1'b0;
            hi_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            rvld_q  <= 1'b0;
            rerr_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            two_q   <= two_d;
            half_q  <= half_d;
            query_q <= query_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            rvld_q  <= rvld_d;
            rerr_q  <= rerr_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        two_d   = two_q;
        half_d  = half_q;
        query_d = query_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        rerr_d  = 1'b0;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    rdata_d = '0;
                    if (cmd_region > 3'd4) begin
                        state_d = ST_RESP;
                        rvld_d  = 1'b1;
                        rerr_d  = 1'b1;
                    end else begin
                        state_d = ST_BEAT;
                        cnt_d   = '0;
                        half_d  = 1'b0;
                        two_d   = is_two_beat(cmd_region);
                        query_d = (cmd_region == REGION_QUERY);
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        sel_d   = 4'hF;
                        we_d    = cmd_we;
                        adr_d   = beat_addr(cmd_region, cmd_index);
                        dat_d   = cmd_we ? cmd_wdata[31:0] : 32'd0;
                        hi_d    = !cmd_we ? 32'd0 :
                                  (cmd_region == REGION_QUERY) ? (cmd_wdata[63:32] & QHI_MASK)
                                                               : cmd_wdata[63:32];
                    end
                end
            end
            ST_BEAT: begin
                if (wbm_ack_i) begin
                    if (!we_q) begin
                        if (half_q) rdata_d[63:32] = query_q ? (wbm_dat_i & QHI_MASK) : wbm_dat_i;
                        else        rdata_d[31:0]  = wbm_dat_i;
                    end
                    stb_d = 1'b0;
                    sel_d = '0;
                    if (two_q && !half_q) begin
                        state_d = ST_GAP;
                        half_d  = 1'b1;
                        adr_d   = adr_q + 32'd1;
                        dat_d   = hi_q;
                    end else begin
                        state_d = ST_RESP;
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                        adr_d   = '0;
                        dat_d   = '0;
                        rvld_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the slave never answered this beat.
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                    rdata_d = '0;
                    rvld_d  = 1'b1;
                    rerr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_BEAT;
                stb_d   = 1'b1;
                sel_d   = 4'hF;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rvld_q;
    assign rsp_err   = rerr_q;
    assign rsp_rdata = rdata_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
